// File: rtl/tri_oai21_pipe_pkg.sv
// ---------------------------------------------------------------------------
// tri_oai21_pipe_pkg
// Shared definitions for the tri_oai21_pipe block: the 2-bit gate-function
// encodings carried on the mode input and the legal parameter ranges.
// ---------------------------------------------------------------------------
package tri_oai21_pipe_pkg;

    // Gate function selected by the mode input of each accepted beat.
    typedef enum logic [1:0] {
        MODE_OAI21 = 2'b00,   // y = ~((a0 | a1) & b0)
        MODE_AOI21 = 2'b01,   // y = ~((a0 & a1) | b0)
        MODE_OA21  = 2'b10,   // y =   (a0 | a1) & b0
        MODE_AO21  = 2'b11    // y =   (a0 & a1) | b0
    } gate_mode_e;

    localparam int MIN_WIDTH  = 1;
    localparam int MAX_WIDTH  = 64;
    localparam int MIN_STAGES = 1;
    localparam int MAX_STAGES = 4;

endpackage

// File: rtl/tri_oai21_pipe_stage.sv
// ---------------------------------------------------------------------------
// tri_oai21_pipe_stage
// One pipeline slice: a WIDTH-wide result register plus its valid bit.
// The slice loads from upstream whenever load_i is high (it is empty or is
// being drained in this same cycle). Flush and reset clear only the valid
// bit; the data register keeps its contents.
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset (clears valid)
//   flush_i     drop the beat held in this slice
//   load_i      slice may take a new beat this cycle
//   up_valid_i  upstream holds a beat to hand over
//   d_i         upstream data
//   valid_o     slice holds a valid beat
//   q_o         slice data
// ---------------------------------------------------------------------------
module tri_oai21_pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             up_valid_i,
    input  logic [0:WIDTH-1] d_i,
    output logic             valid_o,
    output logic [0:WIDTH-1] q_o
);

    logic             valid_q;
    logic             valid_d;
    logic [0:WIDTH-1] data_q;
    logic             data_en;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            // An empty upstream turns a loading slice into a bubble.
            valid_d = up_valid_i;
        end
    end

    // Only capture real beats so the data register is quiet on bubbles and
    // untouched on flush.
    assign data_en = load_i & up_valid_i & ~flush_i & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_en) begin
            data_q <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/tri_oai21_pipe.sv
// ---------------------------------------------------------------------------
// tri_oai21_pipe
// Valid/ready pipelined OAI21/AOI21/OA21/AO21 gate over WIDTH independent
// lanes (bit 0 is the MSB). The gate is evaluated combinationally on the
// incoming beat; STAGES slices then carry only the result and a valid bit.
// The load chain is computed combinationally from out_ready backwards, so
// a full pipe still accepts one beat per cycle while the consumer is ready.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   mode       gate function of the presented beat
//   in_valid   input beat presented
//   in_ready   input beat can be accepted this cycle
//   a0,a1,b0   operand lanes
//   flush      discard every beat in flight
//   y          result of the oldest beat (final-stage register)
//   out_valid  y is valid
//   out_ready  consumer takes y this cycle
//   busy       any slice holds a valid beat
// ---------------------------------------------------------------------------
module tri_oai21_pipe
    import tri_oai21_pipe_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:1]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] a0,
    input  logic [0:WIDTH-1] a1,
    input  logic [0:WIDTH-1] b0,
    input  logic             flush,
    output logic [0:WIDTH-1] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    logic [0:WIDTH-1] gate_y;
    logic [0:WIDTH-1] stage_data [0:STAGES];
    logic [STAGES:0]  stage_valid;
    logic [STAGES:1]  stage_load;
    logic             ready_chain;

    // Gate function ahead of stage 1.
    always_comb begin
        gate_y = '0;
        case (gate_mode_e'(mode))
            MODE_OAI21: gate_y = ~((a0 | a1) & b0);
            MODE_AOI21: gate_y = ~((a0 & a1) | b0);
            MODE_OA21:  gate_y =   (a0 | a1) & b0;
            MODE_AO21:  gate_y =   (a0 & a1) | b0;
        endcase
    end

    // Walk from the output back to stage 1: a slice can load when it is
    // empty or when everything downstream of it moves this cycle.
    always_comb begin
        stage_load  = '0;
        ready_chain = out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            stage_load[k] = ~stage_valid[k] | ready_chain;
            ready_chain   = stage_load[k];
        end
    end

    assign stage_data[0]  = gate_y;
    assign stage_valid[0] = in_valid;

    generate
        for (genvar gi = 1; gi <= STAGES; gi++) begin : g_stage
            tri_oai21_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush_i    (flush),
                .load_i     (stage_load[gi]),
                .up_valid_i (stage_valid[gi-1]),
                .d_i        (stage_data[gi-1]),
                .valid_o    (stage_valid[gi]),
                .q_o        (stage_data[gi])
            );
        end
    endgenerate

    // Nothing enters during reset or flush; stage 1 discards the beat anyway.
    assign in_ready  = rst_n & ~flush & stage_load[1];
    assign y         = stage_data[STAGES];
    assign out_valid = stage_valid[STAGES];
    assign busy      = |stage_valid[STAGES:1];

endmodule

// File: tb/tb_tri_oai21_pipe.sv
// ---------------------------------------------------------------------------
// tb_tri_oai21_pipe
// Directed scenarios on a WIDTH=4/STAGES=2 instance plus a randomized
// scoreboard run on STAGES=1 and STAGES=4 instances (WIDTH=8).
// ---------------------------------------------------------------------------
module tb_tri_oai21_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Main instance (WIDTH=4, STAGES=2)
    logic       rst_n, flush, in_valid, out_ready;
    logic [0:1] mode;
    logic [0:3] a0, a1, b0;
    logic       in_ready, out_valid, busy;
    logic [0:3] y;

    tri_oai21_pipe #(.WIDTH(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .a0(a0), .a1(a1), .b0(b0), .flush(flush),
        .y(y), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    // Random-run instances share operands and handshake inputs.
    logic       r_in_valid, r_out_ready;
    logic [0:1] r_mode;
    logic [0:7] r_a0, r_a1, r_b0;
    logic       p1_in_ready, p1_out_valid, p1_busy;
    logic [0:7] p1_y;
    logic       p4_in_ready, p4_out_valid, p4_busy;
    logic [0:7] p4_y;

    tri_oai21_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .mode(r_mode), .in_valid(r_in_valid),
        .in_ready(p1_in_ready), .a0(r_a0), .a1(r_a1), .b0(r_b0), .flush(flush),
        .y(p1_y), .out_valid(p1_out_valid), .out_ready(r_out_ready), .busy(p1_busy)
    );

    tri_oai21_pipe #(.WIDTH(8), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .mode(r_mode), .in_valid(r_in_valid),
        .in_ready(p4_in_ready), .a0(r_a0), .a1(r_a1), .b0(r_b0), .flush(flush),
        .y(p4_y), .out_valid(p4_out_valid), .out_ready(r_out_ready), .busy(p4_busy)
    );

    // Reference: lane-by-lane truth of the four gate functions.
    function automatic logic [63:0] ref_gate(input int m, input logic [63:0] a,
                                             input logic [63:0] b, input logic [63:0] c,
                                             input int w);
        logic [63:0] r;
        int ai, bi, ci, x;
        r = '0;
        for (int i = 0; i < w; i++) begin
            ai = int'(a[i]);
            bi = int'(b[i]);
            ci = int'(c[i]);
            if (m == 0 || m == 2) x = ((ai + bi) > 0 && ci == 1) ? 1 : 0;
            else                  x = ((ai * bi) == 1 || ci == 1) ? 1 : 0;
            if (m < 2) x = 1 - x;
            r[i] = x[0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mode = 2'b00; a0 = '0; a1 = '0; b0 = '0;
        r_in_valid = 1'b0; r_out_ready = 1'b1; r_mode = 2'b00;
        r_a0 = '0; r_a1 = '0; r_b0 = '0;
        repeat (3) tick();
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({busy, p1_busy, p4_busy} !== 3'b000)
            $display("FAIL reset_busy: got %b%b%b want 000", busy, p1_busy, p4_busy);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_oai21();
        mode = 2'b00; a0 = 4'b1100; a1 = 4'b1010; b0 = 4'b1111;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL oai21_accept: in_ready %b want 1", in_ready);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL oai21_early: out_valid %b want 0 at N+1", out_valid);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 4'b0001)
            $display("FAIL oai21_result: out_valid %b y %b want 1 0001", out_valid, y);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL oai21_single: out_valid %b want 0", out_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_mode_mix();
        a0 = 4'b1100; a1 = 4'b1010; b0 = 4'b0001; out_ready = 1'b1;
        mode = 2'b01; in_valid = 1'b1;
        tick();
        mode = 2'b11;
        tick();
        in_valid = 1'b0; mode = 2'b00;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 4'b0110)
            $display("FAIL aoi21_result: out_valid %b y %b want 1 0110", out_valid, y);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 4'b1001)
            $display("FAIL ao21_result: out_valid %b y %b want 1 1001", out_valid, y);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [0:1] bp_m [8];
        logic [0:3] bp_a [8];
        logic [0:3] bp_b [8];
        logic [0:3] bp_c [8];
        logic [0:3] bp_e [8];
        int idx, got, first_c, last_c;
        for (int i = 0; i < 8; i++) begin
            bp_m[i] = 2'($urandom_range(0, 3));
            bp_a[i] = 4'($urandom);
            bp_b[i] = 4'($urandom);
            bp_c[i] = 4'($urandom);
            bp_e[i] = 4'(ref_gate(int'(bp_m[i]), 64'(bp_a[i]), 64'(bp_b[i]), 64'(bp_c[i]), 4));
        end
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            mode = bp_m[idx]; a0 = bp_a[idx]; a1 = bp_b[idx]; b0 = bp_c[idx];
            @(negedge clk);
            if (c >= 2) begin
                total_cnt++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready);
                else pass_cnt++;
                total_cnt++;
                if (out_valid !== 1'b1 || y !== bp_e[0])
                    $display("FAIL bp_hold c%0d: out_valid %b y %b want 1 %b", c, out_valid, y, bp_e[0]);
                else pass_cnt++;
            end
            if (in_ready === 1'b1) idx++;
            tick();
        end
        total_cnt++;
        if (idx != 2) $display("FAIL bp_accepts: got %0d want 2", idx);
        else pass_cnt++;

        out_ready = 1'b1;
        got = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            in_valid = (idx < 8);
            if (idx < 8) begin
                mode = bp_m[idx]; a0 = bp_a[idx]; a1 = bp_b[idx]; b0 = bp_c[idx];
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                total_cnt++;
                if (y !== bp_e[got]) $display("FAIL bp_drain beat%0d: y %b want %b", got, y, bp_e[got]);
                else pass_cnt++;
                if (got == 0) first_c = cyc;
                last_c = cyc;
                got++;
            end
            if (in_valid && in_ready === 1'b1) idx++;
            tick();
        end
        in_valid = 1'b0;
        total_cnt++;
        if (got != 8) $display("FAIL bp_drain_count: got %0d want 8", got);
        else pass_cnt++;
        total_cnt++;
        if (last_c - first_c != 7) $display("FAIL bp_drain_rate: span %0d want 7", last_c - first_c);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b0;
        mode = 2'b10; a0 = 4'b0101; a1 = 4'b0011; b0 = 4'b1111; in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++;
            if (in_ready !== 1'b1) $display("FAIL flush_fill%0d: in_ready %b want 1", c, in_ready);
            else pass_cnt++;
            tick();
        end
        flush = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready);
        else pass_cnt++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL flush_clear: out_valid %b busy %b want 0 0", out_valid, busy);
        else pass_cnt++;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL flush_leak: %0d output beats want 0", seen);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        mode = 2'b11; a0 = 4'b1111; a1 = 4'b1111; b0 = 4'b0000; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL midreset_clear: out_valid %b busy %b in_ready %b want 0 0 0",
                     out_valid, busy, in_ready);
        else pass_cnt++;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        mode = 2'b10; a0 = 4'b0110; a1 = 4'b0011; b0 = 4'b1101; in_valid = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL midreset_accept: in_ready %b want 1", in_ready);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midreset_partial: out_valid %b want 0", out_valid);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 4'b0101)
            $display("FAIL midreset_result: out_valid %b y %b want 1 0101", out_valid, y);
        else pass_cnt++;
        tick();
    endtask

    typedef struct {
        logic [0:7] d;
        int         c;
    } beat_t;

    beat_t q1[$];
    beat_t q4[$];

    task automatic run_pipes(input int ncyc, input bit rand_ready, input bit feed, input bit chk_lat);
        beat_t      b;
        logic [0:7] e;
        for (int n = 0; n < ncyc; n++) begin
            r_in_valid  = feed && ($urandom_range(0, 3) != 0);
            r_mode      = 2'($urandom_range(0, 3));
            r_a0        = 8'($urandom);
            r_a1        = 8'($urandom);
            r_b0        = 8'($urandom);
            r_out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            e = 8'(ref_gate(int'(r_mode), 64'(r_a0), 64'(r_a1), 64'(r_b0), 8));
            @(negedge clk);
            if (p1_out_valid === 1'b1 && r_out_ready) begin
                total_cnt++;
                if (q1.size() == 0) $display("FAIL s1_extra: unexpected beat y %b", p1_y);
                else begin
                    b = q1.pop_front();
                    if (p1_y !== b.d) $display("FAIL s1_data: y %b want %b", p1_y, b.d);
                    else pass_cnt++;
                    if (chk_lat) begin
                        total_cnt++;
                        if (cyc - b.c != 1) $display("FAIL s1_latency: got %0d want 1", cyc - b.c);
                        else pass_cnt++;
                    end
                end
            end
            if (p4_out_valid === 1'b1 && r_out_ready) begin
                total_cnt++;
                if (q4.size() == 0) $display("FAIL s4_extra: unexpected beat y %b", p4_y);
                else begin
                    b = q4.pop_front();
                    if (p4_y !== b.d) $display("FAIL s4_data: y %b want %b", p4_y, b.d);
                    else pass_cnt++;
                    if (chk_lat) begin
                        total_cnt++;
                        if (cyc - b.c != 4) $display("FAIL s4_latency: got %0d want 4", cyc - b.c);
                        else pass_cnt++;
                    end
                end
            end
            if (r_in_valid && p1_in_ready === 1'b1) q1.push_back('{d: e, c: cyc});
            if (r_in_valid && p4_in_ready === 1'b1) q4.push_back('{d: e, c: cyc});
            tick();
        end
        r_in_valid = 1'b0;
    endtask

    task automatic test_random_pipes();
        run_pipes(300, 1'b0, 1'b1, 1'b1);
        run_pipes(8,   1'b0, 1'b0, 1'b1);
        run_pipes(400, 1'b1, 1'b1, 1'b0);
        run_pipes(12,  1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if (q1.size() != 0 || q4.size() != 0)
            $display("FAIL random_lost: pending s1 %0d s4 %0d want 0 0", q1.size(), q4.size());
        else pass_cnt++;
        total_cnt++;
        if (p1_busy !== 1'b0 || p4_busy !== 1'b0)
            $display("FAIL random_busy: s1 %b s4 %b want 0 0", p1_busy, p4_busy);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_oai21();
        test_mode_mix();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random_pipes();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tri_oai21_pipe.md
TRI_OAI21_PIPE -- requirements
Module: tri_oai21_pipe

Interface
REQ-001 Parameter WIDTH, default 1: number of independent bit lanes, range 1..64.
REQ-002 Parameter STAGES, default 2: number of pipeline register slices, range 1..4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous to clk and active-low.
REQ-005 mode  input  [0:1]  gate function, sampled with each accepted input beat: 00 OAI21, 01 AOI21, 10 OA21, 11 AO21.
REQ-006 in_valid  input  1  an input beat is presented on a0/a1/b0/mode.
REQ-007 in_ready  output  1  the block can accept the presented beat this cycle.
REQ-008 a0, a1, b0  input  [0:WIDTH-1]  operand lanes; bit 0 is the MSB.
REQ-009 flush  input  1  discards all beats currently in flight.
REQ-010 y  output  [0:WIDTH-1]  result of the oldest beat in flight.
REQ-011 out_valid  output  1  y holds a valid result.
REQ-012 out_ready  input  1  the consumer accepts y this cycle.
REQ-013 busy  output  1  at least one stage holds a valid beat.

Function
REQ-014 Per-lane functions: OAI21 y=~((a0|a1)&b0); AOI21 y=~((a0&a1)|b0); OA21 y=(a0|a1)&b0; AO21 y=(a0&a1)|b0.
REQ-015 The gate function is evaluated combinationally before stage 1; only the WIDTH result bits and a valid bit are stored per stage.
REQ-016 An input beat is accepted in a cycle where in_valid and in_ready are both 1.
REQ-017 An output beat is consumed in a cycle where out_valid and out_ready are both 1.
REQ-018 Stage k loads from stage k-1 (or from the input for k=1) when stage k is empty or stage k advances in the same cycle.
REQ-019 in_ready = ~valid[1] | advance[1]; the advance chain is combinational from out_ready, so there are no bubbles.
REQ-020 Latency: with out_ready held at 1, a beat accepted in cycle N appears with out_valid=1 in cycle N+STAGES.
REQ-021 Throughput: 1 beat/cycle sustained while out_ready=1; no beat is dropped or duplicated under any out_ready pattern.
REQ-022 Backpressure: while out_valid=1 and out_ready=0, y and out_valid hold stable; in_ready falls once all STAGES slots are full.
REQ-023 Ordering: results leave in strict acceptance order; each beat keeps the mode sampled at its acceptance.
REQ-024 Flush: in the flush cycle, all valid bits clear on the next edge; any input beat offered in that cycle is not accepted (in_ready=0 while flush=1); data registers are left unchanged.
REQ-025 Flush takes priority over a simultaneous accept or consume; a consume during flush is still seen by the consumer as a completed handshake.
REQ-026 busy = OR of all stage valid bits.
REQ-027 y is don't-care while out_valid=0; y is driven directly from the final-stage register.

Reset
REQ-028 While rst_n=0 at a clock edge, all stage valid bits clear to 0; data registers are not reset.
REQ-029 During and after reset: out_valid=0, busy=0, in_ready=0 while rst_n=0, in_ready=1 in the first cycle after rst_n=1.
REQ-030 A reset asserted mid-stream discards all in-flight beats with no partial output.

Structure
REQ-031 Mode encodings (OAI21, AOI21, OA21, AO21) are named constants in the shared trilib package/header.
REQ-032 One sub-module, tri_oai21_pipe_stage: a WIDTH-wide data register, a valid bit, load/advance logic, reset and flush; it is instantiated STAGES times by a generate loop.
REQ-033 The gate-function logic is in the top level, ahead of stage 1.
REQ-034 No latches and no asynchronous logic.

Verification (WIDTH=4, STAGES=2 unless stated)
REQ-035 mode=00, a0=1100, a1=1010, b0=1111, out_ready=1 -> y=0001 with out_valid=1 exactly 2 cycles after accept.
REQ-036 mode=01, a0=1100, a1=1010, b0=0001 -> y=0110; mode=11 with the same operands -> y=1001; consecutive beats keep their own mode.
REQ-037 Stream 8 beats with out_ready=0 -> in_ready falls after 2 accepts; y is stable; releasing out_ready drains all 8 beats in order, 1 per cycle.
REQ-038 Fill both stages, then assert flush together with in_valid=1 -> next cycle out_valid=0, busy=0, and the offered beat is not accepted.
REQ-039 Assert rst_n=0 with 2 beats in flight -> out_valid=0 after the edge; the first beat after reset is output correctly.
REQ-040 Run with STAGES=1 and STAGES=4 and random in_valid/out_ready -> a scoreboard shows no loss, no duplication, correct order, and latency equal to STAGES when out_ready=1.
